// File: rtl/mac_st_job_ctrl.sv
// mac_st_job_ctrl: job sequencer in front of one ST MAC (8x8 / 2x(4x4) / 4x(2x2)).
// A job (beat count, precision config) clears the MAC accumulator, streams the
// operand beats into the MAC, waits out the MAC pipeline and returns the sum
// on a valid/ready result port. This block is the only driver of the MAC's
// accumulator clear and precision config.
module mac_st_job_ctrl #(
  parameter int HEADROOM = 4,
  parameter int LEN_W    = 8,
  parameter int MAC_LAT  = 2
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  input  logic                    i_cmd_valid,
  output logic                    o_cmd_ready,
  input  logic [LEN_W-1:0]        i_cmd_len,
  input  logic [1:0]              i_cmd_config,
  input  logic                    i_in_valid,
  output logic                    o_in_ready,
  input  logic [7:0]              i_in_a,
  input  logic [7:0]              i_in_w,
  output logic [7:0]              o_mac_a,
  output logic [7:0]              o_mac_w,
  output logic [1:0]              o_mac_config_aw,
  output logic                    o_mac_accu_rst,
  input  logic [16+HEADROOM-1:0]  i_mac_z,
  output logic                    o_out_valid,
  input  logic                    i_out_ready,
  output logic [16+HEADROOM-1:0]  o_out_z
);

  localparam int ZW = 16 + HEADROOM;
  localparam int DW = (MAC_LAT < 1) ? 1 : $clog2(MAC_LAT + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_RUN,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t            r_state;
  state_t            w_next_state;

  logic [LEN_W-1:0]  r_beats_left;
  logic [1:0]        r_cfg;
  logic [DW-1:0]     r_drain_cnt;

  logic [7:0]        r_mac_a;
  logic [7:0]        r_mac_w;
  logic [1:0]        r_mac_cfg;
  logic              r_mac_accu_rst;

  logic              r_out_valid;
  logic [ZW-1:0]     r_out_z;

  logic              w_cmd_ready;
  logic              w_in_ready;
  logic              w_cmd_take;
  logic              w_beat_take;
  logic              w_last_beat;
  logic              w_drain_load;
  logic              w_capture;
  logic              w_handoff;
  logic [1:0]        w_cfg_mapped;

  // The unused encoding 10 runs as full 8x8 precision.
  assign w_cfg_mapped = (i_cmd_config == 2'b10) ? 2'b00 : i_cmd_config;

  // State register.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state decode plus the per-cycle handshake strobes.
  always_comb begin
    w_next_state = r_state;
    w_cmd_ready  = 1'b0;
    w_in_ready   = 1'b0;
    w_cmd_take   = 1'b0;
    w_beat_take  = 1'b0;
    w_last_beat  = 1'b0;
    w_drain_load = 1'b0;
    w_capture    = 1'b0;
    w_handoff    = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_cmd_ready = 1'b1;
        if (i_cmd_valid) begin
          w_cmd_take   = 1'b1;
          w_next_state = S_CLEAR;
        end
      end
      S_CLEAR: begin
        if (r_beats_left != '0) begin
          w_next_state = S_RUN;
        end else begin
          w_drain_load = 1'b1;
          w_next_state = S_DRAIN;
        end
      end
      S_RUN: begin
        w_in_ready = 1'b1;
        if (i_in_valid) begin
          w_beat_take = 1'b1;
          if (r_beats_left == LEN_W'(1)) begin
            w_last_beat  = 1'b1;
            w_drain_load = 1'b1;
            w_next_state = S_DRAIN;
          end
        end
      end
      S_DRAIN: begin
        if (r_drain_cnt == '0) begin
          w_capture    = 1'b1;
          w_next_state = S_DONE;
        end
      end
      S_DONE: begin
        if (i_out_ready) begin
          w_handoff    = 1'b1;
          w_next_state = S_IDLE;
        end
      end
      default: begin
        w_next_state = S_IDLE;
      end
    endcase
  end

  // Job length and precision are latched at acceptance and counted down per beat.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_beats_left <= '0;
      r_cfg        <= 2'b00;
    end else if (w_cmd_take) begin
      r_beats_left <= i_cmd_len;
      r_cfg        <= w_cfg_mapped;
    end else if (w_beat_take) begin
      r_beats_left <= r_beats_left - 1'b1;
    end
  end

  // Drain counter covers the MAC pipeline after the last beat (or the clear).
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_drain_cnt <= '0;
    end else if (w_drain_load) begin
      r_drain_cnt <= DW'(MAC_LAT);
    end else if ((r_state == S_DRAIN) && (r_drain_cnt != '0)) begin
      r_drain_cnt <= r_drain_cnt - 1'b1;
    end
  end

  // Operands carry a beat only on its accept edge; every other cycle adds zero.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_mac_a <= '0;
      r_mac_w <= '0;
    end else if (w_beat_take) begin
      r_mac_a <= i_in_a;
      r_mac_w <= i_in_w;
    end else begin
      r_mac_a <= '0;
      r_mac_w <= '0;
    end
  end

  // Accumulator clear pulses for one cycle and the precision config moves only on the clear edge.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_mac_accu_rst <= 1'b0;
      r_mac_cfg      <= 2'b00;
    end else begin
      r_mac_accu_rst <= (r_state == S_CLEAR);
      if (r_state == S_CLEAR) begin
        r_mac_cfg <= r_cfg;
      end
    end
  end

  // Result capture once the pipeline has drained, held until the consumer takes it.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_out_valid <= 1'b0;
      r_out_z     <= '0;
    end else if (w_capture) begin
      r_out_valid <= 1'b1;
      r_out_z     <= i_mac_z;
    end else if (w_handoff) begin
      r_out_valid <= 1'b0;
    end
  end

  assign o_cmd_ready     = w_cmd_ready;
  assign o_in_ready      = w_in_ready;
  assign o_mac_a         = r_mac_a;
  assign o_mac_w         = r_mac_w;
  assign o_mac_config_aw = r_mac_cfg;
  assign o_mac_accu_rst  = r_mac_accu_rst;
  assign o_out_valid     = r_out_valid;
  assign o_out_z         = r_out_z;

endmodule

// File: tb/tb_mac_st_job_ctrl.sv
// tb_mac_st_job_ctrl: bench for the MAC job sequencer with a behavioural ST MAC
// stand-in (two-edge pipeline), a job table and a result scoreboard.
module tb_mac_st_job_ctrl;

  localparam int EXP_LAT = 3;

  logic        clk;
  logic        rst;
  logic        cmdValid;
  logic        cmdReady;
  logic [7:0]  cmdLen;
  logic [1:0]  cmdConfig;
  logic        inValid;
  logic        inReady;
  logic [7:0]  inA;
  logic [7:0]  inW;
  logic [7:0]  macA;
  logic [7:0]  macW;
  logic [1:0]  macCfg;
  logic        macAccuRst;
  logic [19:0] macZ;
  logic        outValid;
  logic        outReady;
  logic [19:0] outZ;

  logic [19:0] macProd = '0;
  logic [19:0] macAcc  = '0;
  int          cycleCount = 0;

  int compared   = 0;
  int mismatched = 0;

  logic [19:0] expQ[$];

  typedef struct {
    logic [1:0]  cfg;
    logic [1:0]  expCfg;
    int          len;
    logic [7:0]  a;
    logic [7:0]  w;
    int          gap;
    int          readyDelay;
    bit          holdCmd;
    logic [19:0] expZ;
  } jobVec;

  jobVec vecs[7];
  string jobName[7];

  mac_st_job_ctrl #(
    .HEADROOM(4),
    .LEN_W(8),
    .MAC_LAT(2)
  ) dut (
    .i_clk(clk),
    .i_rst(rst),
    .i_cmd_valid(cmdValid),
    .o_cmd_ready(cmdReady),
    .i_cmd_len(cmdLen),
    .i_cmd_config(cmdConfig),
    .i_in_valid(inValid),
    .o_in_ready(inReady),
    .i_in_a(inA),
    .i_in_w(inW),
    .o_mac_a(macA),
    .o_mac_w(macW),
    .o_mac_config_aw(macCfg),
    .o_mac_accu_rst(macAccuRst),
    .i_mac_z(macZ),
    .o_out_valid(outValid),
    .i_out_ready(outReady),
    .o_out_z(outZ)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Edge counter, read only at negedges so it never races the edge itself.
  always @(posedge clk) cycleCount <= cycleCount + 1;

  // Lane products of the ST MAC; narrower modes pair a's lanes with w's lanes in reverse order.
  function automatic logic [19:0] macProduct(input logic [7:0] a, input logic [7:0] w, input logic [1:0] cfg);
    logic [19:0] p;
    case (cfg)
      2'b01:   p = 20'(a[3:0]) * 20'(w[7:4]) + 20'(a[7:4]) * 20'(w[3:0]);
      2'b11:   p = 20'(a[1:0]) * 20'(w[7:6]) + 20'(a[3:2]) * 20'(w[5:4])
                 + 20'(a[5:4]) * 20'(w[3:2]) + 20'(a[7:6]) * 20'(w[1:0]);
      default: p = 20'(a) * 20'(w);
    endcase
    return p;
  endfunction

  // MAC stand-in: product register then accumulator, not touched by the sequencer reset.
  always @(posedge clk) begin
    macProd <= macProduct(macA, macW, macCfg);
    if (macAccuRst) macAcc <= '0;
    else            macAcc <= macAcc + macProd;
  end
  assign macZ = macAcc;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  // Runs one job from the table end to end and scores everything observed along the way.
  task automatic applyStimulus(input int idx);
    jobVec       v;
    string       nm;
    int          cyc;
    int          beats;
    int          gapCnt;
    int          validCycles;
    int          accuEdge;
    int          accuCycles;
    int          lastBeatEdge;
    int          validEdge;
    bit          accept;
    bit          handoff;
    bit          done;
    bit          seenValid;
    bit          cfgBad;
    bit          inReadySeen;
    bit          busyCmdReady;
    bit          zUnstable;
    logic [19:0] firstZ;
    logic [19:0] zAtReady;
    logic [19:0] expZ;

    v  = vecs[idx];
    nm = jobName[idx];
    expQ.push_back(v.expZ);

    cyc = 0;
    while (!cmdReady && cyc < 50) begin
      @(negedge clk);
      cyc++;
    end
    checkOutput({nm, "/cmdReadyIdle"}, 32'(cmdReady), 32'd1);

    cmdValid  = 1'b1;
    cmdLen    = 8'(v.len);
    cmdConfig = v.cfg;
    @(posedge clk);
    @(negedge clk);
    cmdValid  = v.holdCmd;
    cmdLen    = 8'hFF;
    cmdConfig = 2'b01;

    beats = 0; gapCnt = 0; validCycles = 0; accuEdge = -1; accuCycles = 0;
    lastBeatEdge = -1; validEdge = -1; done = 0; seenValid = 0; cfgBad = 0;
    inReadySeen = 0; busyCmdReady = 0; zUnstable = 0; firstZ = '0; zAtReady = '0;

    for (int c = 0; c < 300 && !done; c++) begin
      if (beats < v.len && gapCnt == 0) begin
        inValid = 1'b1; inA = v.a; inW = v.w;
      end else begin
        inValid = 1'b0; inA = 8'hAA; inW = 8'h55;
      end
      outReady = (v.readyDelay == 0) ? 1'b1 : (validCycles > v.readyDelay);
      accept   = inValid && inReady;
      handoff  = outValid && outReady;
      zAtReady = outZ;
      @(posedge clk);
      if (handoff) done = 1;
      @(negedge clk);
      if (accept) begin
        beats++;
        lastBeatEdge = cycleCount;
        gapCnt = v.gap;
      end else if (gapCnt > 0) begin
        gapCnt--;
      end
      if (!done) begin
        if (macAccuRst) begin
          accuCycles++;
          if (accuEdge < 0) accuEdge = cycleCount;
        end
        if (accuEdge >= 0 && macCfg !== v.expCfg) cfgBad = 1;
        if (inReady && v.len == 0) inReadySeen = 1;
        if (cmdReady) busyCmdReady = 1;
        if (outValid) begin
          if (!seenValid) begin
            seenValid = 1;
            validEdge = cycleCount;
            firstZ    = outZ;
          end else if (outZ !== firstZ) begin
            zUnstable = 1;
          end
          validCycles++;
        end
      end
    end
    cmdValid = 1'b0;
    inValid  = 1'b0;

    if (!done) begin
      checkOutput({nm, "/handoffTimeout"}, 32'd0, 32'd1);
      if (expQ.size() > 0) void'(expQ.pop_front());
    end else if (expQ.size() == 0) begin
      checkOutput({nm, "/scoreboardEmpty"}, 32'd1, 32'd0);
    end else begin
      expZ = expQ.pop_front();
      checkOutput({nm, "/outZ"}, 32'(zAtReady), 32'(expZ));
    end

    if (v.len > 0) checkOutput({nm, "/latencyFromLastBeat"}, 32'(validEdge - lastBeatEdge), 32'(EXP_LAT));
    else           checkOutput({nm, "/latencyFromClear"}, 32'(validEdge - accuEdge), 32'(EXP_LAT));
    if (v.len == 0) checkOutput({nm, "/inReadyNeverHigh"}, 32'(inReadySeen), 32'd0);
    checkOutput({nm, "/beatsTaken"}, 32'(beats), 32'(v.len));
    checkOutput({nm, "/accuRstCycles"}, 32'(accuCycles), 32'd1);
    checkOutput({nm, "/macCfgHeld"}, 32'(cfgBad), 32'd0);
    checkOutput({nm, "/cmdReadyBusy"}, 32'(busyCmdReady), 32'd0);
    checkOutput({nm, "/outZStable"}, 32'(zUnstable), 32'd0);
    checkOutput({nm, "/outValidAfterHandoff"}, 32'(outValid), 32'd0);
    checkOutput({nm, "/cmdReadyAfterHandoff"}, 32'(cmdReady), 32'd1);
  endtask

  // Starts a 4-beat 4x4 job, resets after two beats and confirms it leaves no trace.
  task automatic resetMidRun();
    int  cyc;
    int  beats;
    bit  accept;
    bit  sawValid;
    bit  sawInReady;

    cyc = 0;
    while (!cmdReady && cyc < 50) begin
      @(negedge clk);
      cyc++;
    end
    cmdValid  = 1'b1;
    cmdLen    = 8'd4;
    cmdConfig = 2'b01;
    @(posedge clk);
    @(negedge clk);
    cmdValid = 1'b0;

    beats = 0;
    cyc   = 0;
    while (beats < 2 && cyc < 50) begin
      inValid = 1'b1; inA = 8'd3; inW = 8'd5;
      accept  = inValid && inReady;
      @(posedge clk);
      @(negedge clk);
      if (accept) beats++;
      cyc++;
    end
    checkOutput("reset/beatsBeforeReset", 32'(beats), 32'd2);
    checkOutput("reset/macCfgBeforeReset", 32'(macCfg), 32'd1);

    rst = 1'b1;
    #1;
    checkOutput("reset/macA", 32'(macA), 32'd0);
    checkOutput("reset/macW", 32'(macW), 32'd0);
    checkOutput("reset/macCfg", 32'(macCfg), 32'd0);
    checkOutput("reset/macAccuRst", 32'(macAccuRst), 32'd0);
    checkOutput("reset/outValid", 32'(outValid), 32'd0);
    checkOutput("reset/outZ", 32'(outZ), 32'd0);
    checkOutput("reset/cmdReady", 32'(cmdReady), 32'd1);
    checkOutput("reset/inReady", 32'(inReady), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    sawValid   = 0;
    sawInReady = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (outValid) sawValid = 1;
      if (inReady)  sawInReady = 1;
    end
    inValid = 1'b0;
    checkOutput("reset/noResultEmitted", 32'(sawValid), 32'd0);
    checkOutput("reset/noBeatConsumed", 32'(sawInReady), 32'd0);
  endtask

  initial begin
    vecs[0] = '{2'b00, 2'b00, 4, 8'd3,   8'd5,   0, 0, 1'b0, 20'd60};
    vecs[1] = '{2'b00, 2'b00, 0, 8'd9,   8'd9,   0, 0, 1'b0, 20'd0};
    vecs[2] = '{2'b01, 2'b01, 2, 8'h21,  8'h13,  0, 0, 1'b0, 20'd14};
    vecs[3] = '{2'b00, 2'b00, 3, 8'd2,   8'd7,   2, 5, 1'b1, 20'd42};
    vecs[4] = '{2'b10, 2'b00, 1, 8'd255, 8'd255, 0, 0, 1'b0, 20'd65025};
    vecs[5] = '{2'b11, 2'b11, 1, 8'hE4,  8'h1B,  0, 2, 1'b0, 20'd14};
    vecs[6] = '{2'b00, 2'b00, 1, 8'd4,   8'd4,   0, 0, 1'b0, 20'd16};
    jobName[0] = "t1_8x8";
    jobName[1] = "t3_zeroLen";
    jobName[2] = "t2_4x4";
    jobName[3] = "t4_backpressure";
    jobName[4] = "t6_cfg10";
    jobName[5] = "mode2x2";
    jobName[6] = "t5_afterReset";

    rst       = 1'b1;
    cmdValid  = 1'b0;
    cmdLen    = '0;
    cmdConfig = 2'b00;
    inValid   = 1'b0;
    inA       = '0;
    inW       = '0;
    outReady  = 1'b0;

    @(negedge clk);
    @(negedge clk);
    checkOutput("init/outValid", 32'(outValid), 32'd0);
    checkOutput("init/outZ", 32'(outZ), 32'd0);
    checkOutput("init/cmdReady", 32'(cmdReady), 32'd1);
    checkOutput("init/inReady", 32'(inReady), 32'd0);
    checkOutput("init/macA", 32'(macA), 32'd0);
    checkOutput("init/macCfg", 32'(macCfg), 32'd0);
    checkOutput("init/macAccuRst", 32'(macAccuRst), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 6; i++) applyStimulus(i);
    resetMidRun();
    applyStimulus(6);

    checkOutput("scoreboardDrained", 32'(expQ.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
